// File: rtl/voice_param_bank.sv
// rtl/voice_param_bank.sv - per-voice note parameter bank with sample-rate voice scan (option: VOICE_PARAM_BANK_ACTIVE_COUNT_EN)
module voice_param_bank #(
    parameter int NUM_VOICES = 16,
    parameter int VOICE_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SPI_note_status,
    input  logic [7:0]            SPI_voice_index,
    input  logic [31:0]           SPI_tuning_code,
    input  logic [6:0]            SPI_velocity,
    input  logic                  SPI_ready_flag,
    input  logic                  sample_strobe,
    output logic                  out_valid,
    output logic [VOICE_BITS-1:0] out_voice,
    output logic [31:0]           out_tuning,
    output logic [6:0]            out_velocity,
    output logic                  out_gate,
    output logic                  out_trigger,
    output logic                  out_last,
    output logic                  err_index,
    output logic                  overrun,
    output logic [VOICE_BITS:0]   active_voices
);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    localparam logic [8:0]            NUM_VOICES_W = 9'(NUM_VOICES);
    localparam logic [VOICE_BITS-1:0] LAST_IDX     = VOICE_BITS'(NUM_VOICES - 1);

    logic [31:0] tuning   [NUM_VOICES];
    logic [6:0]  velocity [NUM_VOICES];
    logic        gate     [NUM_VOICES];
    logic        trig     [NUM_VOICES];

    state_t                state, state_nxt;
    logic [VOICE_BITS-1:0] idx, idx_nxt;
    logic                  r_ready;
    logic                  note_event;
    logic                  index_bad;
    logic                  wr_en;
    logic [VOICE_BITS-1:0] wr_voice;
    logic                  emit;
    logic                  emit_last;
    logic                  overrun_set;

    assign note_event = SPI_ready_flag & ~r_ready;
    assign index_bad  = {1'b0, SPI_voice_index} >= NUM_VOICES_W;
    assign wr_en      = note_event & ~index_bad;
    assign wr_voice   = SPI_voice_index[VOICE_BITS-1:0];

    // Delay the ready flag for rising-edge detection; resets high so a flag already up is ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ready <= 1'b1;
        else       r_ready <= SPI_ready_flag;
    end

    // Scan FSM state and voice index register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Scan FSM next state: a strobe in IDLE starts a full pass, strobes during a pass are ignored
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                idx_nxt = '0;
                if (sample_strobe) state_nxt = S_SCAN;
            end
            S_SCAN: begin
                if (idx == LAST_IDX) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Scan FSM outputs: which voice is emitted this cycle and whether a strobe collided with the pass
    always_comb begin
        emit        = (state == S_SCAN);
        emit_last   = (state == S_SCAN) && (idx == LAST_IDX);
        overrun_set = (state == S_SCAN) && sample_strobe;
    end

    // Parameter bank; a note-on trigger set is written after the emit clear so it survives a same-cycle emit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                tuning[i]   <= '0;
                velocity[i] <= '0;
                gate[i]     <= 1'b0;
                trig[i]     <= 1'b0;
            end
        end else begin
            if (emit) trig[idx] <= 1'b0;
            if (wr_en) begin
                if (SPI_note_status) begin
                    tuning[wr_voice]   <= SPI_tuning_code;
                    velocity[wr_voice] <= SPI_velocity;
                    gate[wr_voice]     <= 1'b1;
                    trig[wr_voice]     <= 1'b1;
                end else begin
                    gate[wr_voice] <= 1'b0;
                end
            end
        end
    end

    // Registered scan outputs; data fields hold between scans, strobes and flags return to zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_voice    <= '0;
            out_tuning   <= '0;
            out_velocity <= '0;
            out_gate     <= 1'b0;
            out_trigger  <= 1'b0;
            out_last     <= 1'b0;
            err_index    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            out_valid   <= emit;
            out_last    <= emit_last;
            out_trigger <= emit & trig[idx];
            err_index   <= note_event & index_bad;
            overrun     <= overrun_set;
            if (emit) begin
                out_voice    <= idx;
                out_tuning   <= tuning[idx];
                out_velocity <= velocity[idx];
                out_gate     <= gate[idx];
            end
        end
    end

`ifdef VOICE_PARAM_BANK_ACTIVE_COUNT_EN
    logic [VOICE_BITS:0] gate_count;

    // Population count of held gates
    always_comb begin
        gate_count = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            gate_count = gate_count + {{VOICE_BITS{1'b0}}, gate[i]};
        end
    end

    // Register the count so it lags each bank change by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) active_voices <= '0;
        else       active_voices <= gate_count;
    end
`else
    assign active_voices = '0;
`endif

endmodule

// File: tb/tb_voice_param_bank.sv
// tb/tb_voice_param_bank.sv - directed self-checking bench for voice_param_bank
module tb_voice_param_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        SPI_note_status = 1'b0;
    logic [7:0]  SPI_voice_index = '0;
    logic [31:0] SPI_tuning_code = '0;
    logic [6:0]  SPI_velocity = '0;
    logic        SPI_ready_flag = 1'b0;
    logic        sample_strobe = 1'b0;
    logic        out_valid;
    logic [3:0]  out_voice;
    logic [31:0] out_tuning;
    logic [6:0]  out_velocity;
    logic        out_gate;
    logic        out_trigger;
    logic        out_last;
    logic        err_index;
    logic        overrun;
    logic [4:0]  active_voices;

    int passed = 0;
    int total  = 0;

    logic [31:0] m_tun  [16];
    logic [6:0]  m_vel  [16];
    logic        m_gate [16];
    logic        m_trig [16];

    voice_param_bank #(.NUM_VOICES(16), .VOICE_BITS(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .SPI_note_status (SPI_note_status),
        .SPI_voice_index (SPI_voice_index),
        .SPI_tuning_code (SPI_tuning_code),
        .SPI_velocity    (SPI_velocity),
        .SPI_ready_flag  (SPI_ready_flag),
        .sample_strobe   (sample_strobe),
        .out_valid       (out_valid),
        .out_voice       (out_voice),
        .out_tuning      (out_tuning),
        .out_velocity    (out_velocity),
        .out_gate        (out_gate),
        .out_trigger     (out_trigger),
        .out_last        (out_last),
        .err_index       (err_index),
        .overrun         (overrun),
        .active_voices   (active_voices)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_tun[i] = '0; m_vel[i] = '0; m_gate[i] = 1'b0; m_trig[i] = 1'b0;
        end
    endtask

    function automatic logic [63:0] exp_voice(input int k);
        return {17'd0, 1'b1, 4'(k), m_tun[k], m_vel[k], m_gate[k], m_trig[k], 1'(k == 15)};
    endfunction

    function automatic logic [63:0] obs_out();
        return {17'd0, out_valid, out_voice, out_tuning, out_velocity, out_gate, out_trigger, out_last};
    endfunction

    task automatic send_event(input logic st, input logic [7:0] vi, input logic [31:0] tc, input logic [6:0] vel);
        SPI_note_status = st; SPI_voice_index = vi; SPI_tuning_code = tc; SPI_velocity = vel;
        SPI_ready_flag = 1'b1;
        tick();
        check($sformatf("err_index v%0d", vi), err_index, (vi >= 8'd16) ? 64'd1 : 64'd0);
        SPI_ready_flag = 1'b0; SPI_note_status = 1'b0; SPI_voice_index = '0;
        SPI_tuning_code = '0; SPI_velocity = '0;
        tick();
        check($sformatf("err_index_end v%0d", vi), err_index, 64'd0);
        if (vi < 8'd16) begin
            if (st) begin
                m_tun[vi[3:0]] = tc; m_vel[vi[3:0]] = vel; m_gate[vi[3:0]] = 1'b1; m_trig[vi[3:0]] = 1'b1;
            end else begin
                m_gate[vi[3:0]] = 1'b0;
            end
        end
    endtask

    task automatic run_scan(input string tag);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("%s voice%0d", tag, k), obs_out(), exp_voice(k));
            m_trig[k] = 1'b0;
        end
        tick();
        check($sformatf("%s idle_after", tag), {out_valid, out_trigger, out_last, out_voice, out_tuning},
              {3'b000, 4'd15, m_tun[15]});
    endtask

    initial begin
        int vcount;
        int lcount;
        int ocount;
        logic [4:0] exp_act;

        model_clear();
        // Flag already high across reset release; fields describe a note-on that must not land
        SPI_ready_flag = 1'b1; SPI_note_status = 1'b1; SPI_voice_index = 8'd5;
        SPI_tuning_code = 32'hDEAD_BEEF; SPI_velocity = 7'd55;
        repeat (3) tick();
        check("reset outputs", obs_out(), 64'd0);
        check("reset flags", {err_index, overrun, active_voices}, 64'd0);
        reset = 1'b0;
        repeat (3) tick();
        check("held flag no err", err_index, 64'd0);
        run_scan("held_flag");

        // Flag low then high: exactly one write to voice 5
        SPI_ready_flag = 1'b0;
        tick();
        SPI_ready_flag = 1'b1;
        tick();
        SPI_ready_flag = 1'b0;
        tick();
        m_tun[5] = 32'hDEAD_BEEF; m_vel[5] = 7'd55; m_gate[5] = 1'b1; m_trig[5] = 1'b1;
        SPI_note_status = 1'b0; SPI_voice_index = '0; SPI_tuning_code = '0; SPI_velocity = '0;
        run_scan("one_write");
        run_scan("one_write_again");

        // Note-on voice 3, then trigger cleared on next scan
        send_event(1'b1, 8'd3, 32'h0012_3456, 7'd100);
        run_scan("on3");
        run_scan("on3_again");

        // Note-off keeps pitch and velocity
        send_event(1'b0, 8'd3, 32'h0, 7'd0);
        run_scan("off3");

        // Out-of-range indices are dropped
        send_event(1'b1, 8'd16, 32'hFFFF_FFFF, 7'd127);
        send_event(1'b1, 8'd200, 32'h1111_1111, 7'd1);
        run_scan("bad_index");

        // Strobes mid-scan and on the last emission, plus note-on to voice 7 as it is emitted
        vcount = 0; lcount = 0; ocount = 0;
        sample_strobe = 1'b1;
        tick();
        for (int c = 1; c <= 19; c++) begin
            sample_strobe = (c == 5) || (c == 16);
            if (c == 8) begin
                SPI_note_status = 1'b1; SPI_voice_index = 8'd7;
                SPI_tuning_code = 32'hCAFE_0007; SPI_velocity = 7'd77; SPI_ready_flag = 1'b1;
            end else begin
                SPI_note_status = 1'b0; SPI_voice_index = '0;
                SPI_tuning_code = '0; SPI_velocity = '0; SPI_ready_flag = 1'b0;
            end
            tick();
            if (out_valid) vcount++;
            if (out_last) lcount++;
            if (overrun) ocount++;
            if (c <= 16) begin
                check($sformatf("overlap voice%0d", c - 1), obs_out(), exp_voice(c - 1));
                m_trig[c - 1] = 1'b0;
            end
            if (c == 8) begin
                m_tun[7] = 32'hCAFE_0007; m_vel[7] = 7'd77; m_gate[7] = 1'b1; m_trig[7] = 1'b1;
            end
            if (c == 5) check("overrun pulse", overrun, 64'd1);
        end
        sample_strobe = 1'b0; SPI_ready_flag = 1'b0;
        check("overlap valid count", 64'(vcount), 64'd16);
        check("overlap last count", 64'(lcount), 64'd1);
        check("overrun count", 64'(ocount), 64'd2);
        run_scan("retrig7");

        // Asynchronous reset in the middle of a scan
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        repeat (9) tick();
        check("pre_reset voice8", {out_valid, out_voice}, {1'b1, 4'd8});
        reset = 1'b1;
        #1;
        check("async reset outputs", obs_out(), 64'd0);
        tick();
        check("reset hold outputs", {obs_out(), err_index, overrun}, 64'd0);
        reset = 1'b0;
        model_clear();
        repeat (4) tick();
        check("no resume after reset", {out_valid, out_last}, 64'd0);
        run_scan("post_midreset");

        // Active-voice count
        send_event(1'b1, 8'd1, 32'h0000_1000, 7'd10);
        send_event(1'b1, 8'd2, 32'h0000_2000, 7'd20);
        send_event(1'b1, 8'd9, 32'h0000_9000, 7'd90);
        send_event(1'b0, 8'd2, 32'h0, 7'd0);
`ifdef VOICE_PARAM_BANK_ACTIVE_COUNT_EN
        exp_act = 5'd2;
`else
        exp_act = 5'd0;
`endif
        check("active after 3on 1off", active_voices, 64'(exp_act));
        send_event(1'b1, 8'd1, 32'h0000_1111, 7'd11);
        send_event(1'b0, 8'd2, 32'h0, 7'd0);
        check("active unchanged", active_voices, 64'(exp_act));
        run_scan("active_bank");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
